// File: rtl/serial_mac_if.sv
// serial_mac_if: start/busy/done handshake plus operand, serial weight and result bus for serial_mac.
interface serial_mac_if #(parameter int WIDTH = 16);
   logic             start;
   logic             clear_acc;
   logic [WIDTH-1:0] input_neuron;
   logic             weight_bit;
   logic             enable;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             overflow;
   modport master(output start, clear_acc, input_neuron, weight_bit, enable,
                  input busy, done, out, overflow);
   modport slave(input start, clear_acc, input_neuron, weight_bit, enable,
                 output busy, done, out, overflow);
endinterface

// File: rtl/serial_mac.sv
// serial_mac: bit-serial signed fixed-point multiply-accumulate; weight arrives LSB first,
// product is added to a wide accumulator and presented rounded and saturated.
module serial_mac #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 10,
   parameter int GUARD = 8
) (
   input logic        clk,
   input logic        reset,
   serial_mac_if.slave bus
);
   localparam int PW    = 2 * WIDTH;
   localparam int ACC_W = PW + GUARD;
   localparam int KW    = $clog2(WIDTH);
   localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) <<< (FRAC - 1);
   localparam logic signed [ACC_W:0] MAXO = (ACC_W + 1)'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_W:0] MINO = ~MAXO;
   typedef enum logic [1:0] {IDLE, SHIFT, ACCUM} state_t;
   state_t                  state_q;
   logic signed [PW-1:0]    a_q, p_q, term_d, p_d;
   logic [KW-1:0]           k_q;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W:0]   sum_d, rsum_d, rnd_d;
   logic [WIDTH-1:0]        out_q, out_d;
   logic                    ovf_q, done_q, busy_q;
   logic                    last_d, sat_acc_d, sat_hi_d, sat_lo_d;
   always_comb begin
      last_d    = k_q == KW'(WIDTH - 1);
      term_d    = a_q <<< k_q;
      // the MSB weight bit carries negative weight
      p_d       = !bus.weight_bit ? p_q : last_d ? p_q - term_d : p_q + term_d;
      sum_d     = $signed({acc_q[ACC_W-1], acc_q}) + $signed({{(ACC_W + 1 - PW){p_q[PW-1]}}, p_q});
      sat_acc_d = sum_d[ACC_W] != sum_d[ACC_W-1];
      acc_d     = !sat_acc_d ? sum_d[ACC_W-1:0]
                : sum_d[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
      rsum_d    = $signed({acc_d[ACC_W-1], acc_d}) + HALF;
      rnd_d     = rsum_d >>> FRAC;
      sat_hi_d  = rnd_d > MAXO;
      sat_lo_d  = rnd_d < MINO;
      out_d     = sat_hi_d ? {1'b0, {(WIDTH - 1){1'b1}}}
                : sat_lo_d ? {1'b1, {(WIDTH - 1){1'b0}}} : rnd_d[WIDTH-1:0];
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         p_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.start) begin
               a_q     <= {{WIDTH{bus.input_neuron[WIDTH-1]}}, bus.input_neuron};
               p_q     <= '0;
               k_q     <= '0;
               state_q <= SHIFT;
               busy_q  <= 1'b1;
               if (bus.clear_acc) begin
                  acc_q <= '0;
                  ovf_q <= 1'b0;
               end
            end
            SHIFT: if (bus.enable) begin
               p_q <= p_d;
               k_q <= k_q + KW'(1);
               if (last_d) state_q <= ACCUM;
            end
            ACCUM: begin
               acc_q   <= acc_d;
               out_q   <= out_d;
               ovf_q   <= ovf_q | sat_acc_d | sat_hi_d | sat_lo_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.out      = out_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_mac.sv
// tb_serial_mac: directed vector table plus stall, ignored-start and mid-op reset sequences.
module tb_serial_mac;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   serial_mac_if #(.WIDTH(16)) bus();
   serial_mac #(.WIDTH(16), .FRAC(10), .GUARD(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {
      logic        cl;
      logic [15:0] a;
      logic [15:0] w;
      logic [15:0] o;
      logic        ov;
   } vec_t;
   vec_t v[14];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask
   task automatic run_op(input logic cl, input logic [15:0] a, input logic [15:0] w,
                         input int stall_at, input int stall_n,
                         output logic [15:0] o, output logic ov, output int lat);
      int t0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.clear_acc = cl;
      bus.input_neuron = a;
      bus.weight_bit = 1'b1;
      bus.enable = 1'b1;
      @(posedge clk);
      #1 t0 = cyc;
      bus.start = 1'b0;
      bus.clear_acc = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == stall_at) begin
            for (int s = 0; s < stall_n; s++) begin
               bus.enable = 1'b0;
               bus.weight_bit = ~w[i];
               bus.start = (s == 0);
               bus.clear_acc = 1'b1;
               bus.input_neuron = 16'h7FFF;
               @(negedge clk);
            end
         end
         bus.start = 1'b0;
         bus.clear_acc = 1'b0;
         bus.enable = 1'b1;
         bus.weight_bit = w[i];
      end
      @(negedge clk);
      bus.enable = 1'b0;
      bus.weight_bit = 1'b1;
      lat = -1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = cyc - t0;
            break;
         end
      end
      o = bus.out;
      ov = bus.overflow;
   endtask
   initial begin
      logic [15:0] o;
      logic        ov;
      int          lat;
      int          n;
      v[0]  = '{1'b1, 16'h8800, 16'h0400, 16'h8800, 1'b0};
      v[1]  = '{1'b1, 16'h0C00, 16'h0800, 16'h1800, 1'b0};
      v[2]  = '{1'b0, 16'h0400, 16'h0400, 16'h1C00, 1'b0};
      v[3]  = '{1'b1, 16'h0400, 16'hFC00, 16'hFC00, 1'b0};
      v[4]  = '{1'b1, 16'h0001, 16'h0200, 16'h0001, 1'b0};
      v[5]  = '{1'b1, 16'hFFFF, 16'h0200, 16'h0000, 1'b0};
      v[6]  = '{1'b1, 16'hFFFF, 16'h0600, 16'hFFFF, 1'b0};
      v[7]  = '{1'b1, 16'h8000, 16'h0800, 16'h8000, 1'b1};
      v[8]  = '{1'b1, 16'h7C00, 16'h0800, 16'h7FFF, 1'b1};
      v[9]  = '{1'b0, 16'h0000, 16'h1234, 16'h7FFF, 1'b1};
      v[10] = '{1'b0, 16'hFC00, 16'h0400, 16'h7FFF, 1'b1};
      v[11] = '{1'b1, 16'h0400, 16'h0400, 16'h0400, 1'b0};
      v[12] = '{1'b1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1};
      v[13] = '{1'b1, 16'h1800, 16'h0A00, 16'h3C00, 1'b0};
      bus.start = 1'b0;
      bus.clear_acc = 1'b0;
      bus.input_neuron = '0;
      bus.weight_bit = 1'b0;
      bus.enable = 1'b0;
      #1 reset = 1'b0;
      #7;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_out", 32'(bus.out), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 14; i++) begin
         run_op(v[i].cl, v[i].a, v[i].w, -1, 0, o, ov, lat);
         chk($sformatf("v%0d_out", i), 32'(o), 32'(v[i].o));
         chk($sformatf("v%0d_ovf", i), 32'(ov), 32'(v[i].ov));
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'd17);
      end
      @(posedge clk);
      #1;
      chk("done_width", 32'(bus.done), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      run_op(1'b1, 16'h0C00, 16'h0800, 6, 3, o, ov, lat);
      chk("stall_out", 32'(o), 32'h1800);
      chk("stall_ovf", 32'(ov), 32'd0);
      chk("stall_lat", 32'(lat), 32'd20);
      n = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) n++;
      end
      chk("no_second_op", 32'(n), 32'd0);
      chk("no_second_busy", 32'(bus.busy), 32'd0);
      chk("stall_out_hold", 32'(bus.out), 32'h1800);
      run_op(1'b1, 16'h7C00, 16'h0800, -1, 0, o, ov, lat);
      chk("pre_rst_out", 32'(o), 32'h7FFF);
      chk("pre_rst_ovf", 32'(ov), 32'd1);
      @(negedge clk);
      bus.start = 1'b1;
      bus.clear_acc = 1'b1;
      bus.input_neuron = 16'h0C00;
      bus.enable = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.clear_acc = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.weight_bit = 1'b1;
         @(negedge clk);
      end
      chk("mid_busy", 32'(bus.busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_busy", 32'(bus.busy), 32'd0);
      chk("async_done", 32'(bus.done), 32'd0);
      chk("async_out", 32'(bus.out), 32'd0);
      chk("async_ovf", 32'(bus.overflow), 32'd0);
      bus.enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_op(1'b0, 16'h0C00, 16'h0800, -1, 0, o, ov, lat);
      chk("post_rst_out", 32'(o), 32'h1800);
      chk("post_rst_ovf", 32'(ov), 32'd0);
      chk("post_rst_lat", 32'(lat), 32'd17);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
